// File: rtl/cache_fill_arbiter_if.sv
// Signal bundle between the fill arbiter, the two cache miss ports and main memory.
// The master modport is the arbiter's view; the slave modport is the surrounding environment.
interface cache_fill_arbiter_if #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
);
    localparam int WORD_W = $clog2(BLOCK_WORDS);

    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_data;
    logic              fill_busy;
    logic              fill_sel;
    logic              data_we;
    logic [WORD_W-1:0] data_word;
    logic [DATA_W-1:0] data_wdata;
    logic              tag_we;
    logic [ADDR_W-1:0] tag_addr;

    modport master (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
        output mem_en, mem_addr, fill_busy, fill_sel, data_we, data_word, data_wdata,
               tag_we, tag_addr
    );

    modport slave (
        output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
        input  mem_en, mem_addr, fill_busy, fill_sel, data_we, data_word, data_wdata,
               tag_we, tag_addr
    );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Block-fill controller for the I/D caches over one pipelined main memory: D-side wins ties,
// reads are issued back-to-back, returned words are steered into the cache, then the tag is written.
module cache_fill_arbiter #(
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_fill_arbiter_if.master bus
);
    // state    | meaning
    // ---------+--------------------------------------------------------------
    // ST_DRAIN | after reset, ignore MEM_LATENCY cycles of stale read returns
    // ST_IDLE  | wait for a miss; D-side wins when both are pending
    // ST_FILL  | issue the block's reads and write each returned word
    // ST_DONE  | one bubble so the filled side can drop its miss
    localparam logic [1:0] ST_DRAIN = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int ISS_W  = WORD_W + 1;
    localparam int DRN_W  = $clog2(MEM_LATENCY + 1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((2 * BLOCK_WORDS) - 1);

    logic [1:0]        state_q, state_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic [ISS_W-1:0]  issue_q, issue_d;
    logic [WORD_W-1:0] recv_q, recv_d;
    logic              fill_sel_q, fill_sel_d;
    logic [ADDR_W-1:0] tag_addr_q, tag_addr_d;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              data_we;
    logic              tag_we;

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        issue_d    = issue_q;
        recv_d     = recv_q;
        fill_sel_d = fill_sel_q;
        tag_addr_d = tag_addr_q;
        mem_en     = 1'b0;
        mem_addr   = '0;
        data_we    = 1'b0;
        tag_we     = 1'b0;

        case (state_q)
            ST_DRAIN: begin
                drain_d = drain_q - DRN_W'(1);
                if (drain_q <= DRN_W'(1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                issue_d = '0;
                recv_d  = '0;
                if (bus.d_miss) begin
                    fill_sel_d = 1'b1;
                    tag_addr_d = bus.d_miss_addr & BLK_MASK;
                    state_d    = ST_FILL;
                end else if (bus.i_miss) begin
                    fill_sel_d = 1'b0;
                    tag_addr_d = bus.i_miss_addr & BLK_MASK;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                // issue_q's top bit sets once all BLOCK_WORDS reads are out
                if (!issue_q[WORD_W]) begin
                    mem_en   = 1'b1;
                    mem_addr = tag_addr_q + ADDR_W'({issue_q[WORD_W-1:0], 1'b0});
                    issue_d  = issue_q + ISS_W'(1);
                end
                if (bus.mem_data_valid) begin
                    data_we = 1'b1;
                    recv_d  = recv_q + WORD_W'(1);
                    if (recv_q == WORD_W'(BLOCK_WORDS - 1)) begin
                        tag_we  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_DRAIN;
        endcase

        // reset takes effect on the outputs in the same cycle, so an aborted block never commits
        if (rst) begin
            mem_en   = 1'b0;
            mem_addr = '0;
            data_we  = 1'b0;
            tag_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_DRAIN;
            drain_q    <= DRN_W'(MEM_LATENCY);
            issue_q    <= '0;
            recv_q     <= '0;
            fill_sel_q <= 1'b0;
            tag_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            issue_q    <= issue_d;
            recv_q     <= recv_d;
            fill_sel_q <= fill_sel_d;
            tag_addr_q <= tag_addr_d;
        end
    end

    assign bus.mem_en     = mem_en;
    assign bus.mem_addr   = mem_addr;
    assign bus.data_we    = data_we;
    assign bus.tag_we     = tag_we;
    assign bus.fill_busy  = rst | (state_q != ST_IDLE);
    assign bus.fill_sel   = fill_sel_q;
    assign bus.data_word  = recv_q;
    assign bus.data_wdata = bus.mem_data;
    assign bus.tag_addr   = tag_addr_q;
endmodule
